gf16_inv_seq: RTL and testbench

// - Sequenced GF(2^4) inverter (field poly x^4+x+1), the nibble-inversion step of the composite-field SubBytes path.
// - Computes a^-1 = a^14 = a^2 * a^4 * a^8 by time-sharing ONE FFMul_K4_Q2 instance, one multiply per step.
// - Sits between the GF(2^8)->GF((2^4)^2) mapping stage and the nibble recombination logic.
// - Valid/ready handshake on both sides; zero maps to zero.

---
 rtl/gf16_pkg.sv | 17 +
 rtl/FFMul_K4_Q2.sv | 22 ++
 rtl/gf16_inv_seq.sv | 127 ++++++++++++
 tb/tb_gf16_inv_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gf16_pkg.sv
// Shared GF(2^4) definitions for the composite-field SubBytes nibble path.
// Field polynomial x^4+x+1; only the low terms are kept for reduction.
package gf16_pkg;
  typedef logic [3:0] gf16_t;

  localparam gf16_t GF16_POLY = 4'b0011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ1  = 3'd1,
    SQ2  = 3'd2,
    SQ3  = 3'd3,
    M1   = 3'd4,
    M2   = 3'd5,
    DONE = 3'd6
  } state_t;
endpackage

// File: rtl/FFMul_K4_Q2.sv
// Combinational GF(2^4) multiplier, reduction by x^4+x+1.
// Shift-and-add over the bits of b, reducing the running multiple of a each step.
module FFMul_K4_Q2
  import gf16_pkg::*;
(
  input  gf16_t a,
  input  gf16_t b,
  output gf16_t y
);
  gf16_t acc;
  gf16_t sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[3] ? ({sh[2:0], 1'b0} ^ GF16_POLY) : {sh[2:0], 1'b0};
    end
    y = acc;
  end
endmodule

// File: rtl/gf16_inv_seq.sv
// Sequenced GF(2^4) inverter: a^-1 = a^14 = a^2 * a^4 * a^8, one shared multiplier.
// Each step state issues one multiply; with MUL_LATENCY=1 the product is registered.
module gf16_inv_seq
  import gf16_pkg::*;
#(
  parameter int MUL_LATENCY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inValid,
  output logic       inReady,
  input  logic [3:0] inData,
  output logic       outValid,
  input  logic       outReady,
  output logic [3:0] outData,
  output logic       busy,
  output logic [2:0] dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. inReady is high only in IDLE; outValid/outData hold steady in DONE until
  // outReady is seen, so the producer and consumer never need to look at each other.
  localparam logic TWO_CYC = (MUL_LATENCY != 0);

  state_t state, state_nxt;
  logic   mul_phase, mul_phase_nxt;
  logic   step, advance;
  gf16_t  a_q, p2_q, p4_q, p8_q, t_q, out_q;
  gf16_t  op_a, op_b, mul_out, prod;

  FFMul_K4_Q2 mul (
    .a(op_a),
    .b(op_b),
    .y(mul_out)
  );

  generate
    if (MUL_LATENCY != 0) begin : g_preg
      gf16_t prod_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) prod_q <= '0;
        else     prod_q <= mul_out;
      end
      assign prod = prod_q;
    end else begin : g_comb
      assign prod = mul_out;
    end
  endgenerate

  always_comb begin
    step    = (state == SQ1) || (state == SQ2) || (state == SQ3) ||
              (state == M1)  || (state == M2);
    advance = step && (!TWO_CYC || mul_phase);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mul_phase <= 1'b0;
    end else begin
      state     <= state_nxt;
      mul_phase <= mul_phase_nxt;
    end
  end

  // Unused encodings fall through to default and return to IDLE.
  always_comb begin
    state_nxt     = state;
    mul_phase_nxt = TWO_CYC && step && !mul_phase;
    case (state)
      IDLE:    if (inValid)  state_nxt = SQ1;
      SQ1:     if (advance)  state_nxt = SQ2;
      SQ2:     if (advance)  state_nxt = SQ3;
      SQ3:     if (advance)  state_nxt = M1;
      M1:      if (advance)  state_nxt = M2;
      M2:      if (advance)  state_nxt = DONE;
      DONE:    if (outReady) state_nxt = IDLE;
      default: begin
        state_nxt     = IDLE;
        mul_phase_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      SQ1:     begin op_a = a_q;  op_b = a_q;  end
      SQ2:     begin op_a = p2_q; op_b = p2_q; end
      SQ3:     begin op_a = p4_q; op_b = p4_q; end
      M1:      begin op_a = p2_q; op_b = p4_q; end
      M2:      begin op_a = t_q;  op_b = p8_q; end
      default: begin op_a = '0;   op_b = '0;   end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      p2_q  <= '0;
      p4_q  <= '0;
      p8_q  <= '0;
      t_q   <= '0;
      out_q <= '0;
    end else begin
      if (state == IDLE && inValid) a_q <= inData;
      if (advance) begin
        case (state)
          SQ1:     p2_q  <= prod;
          SQ2:     p4_q  <= prod;
          SQ3:     p8_q  <= prod;
          M1:      t_q   <= prod;
          M2:      out_q <= prod;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    inReady   = (state == IDLE);
    busy      = (state != IDLE);
    outValid  = (state == DONE);
    outData   = out_q;
    dbg_state = state;
  end
endmodule

// File: tb/tb_gf16_inv_seq.sv
// Directed bench for gf16_inv_seq: one instance per MUL_LATENCY build.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gf16_inv_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, busy0;
  logic [3:0] in_data0 = '0, out_data0;
  logic [2:0] dbg0;
  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, busy1;
  logic [3:0] in_data1 = '0, out_data1;
  logic [2:0] dbg1;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] INV_TAB [16] = '{4'd0, 4'd1, 4'd9, 4'd14, 4'd13, 4'd11, 4'd7, 4'd6,
                                          4'd15, 4'd2, 4'd12, 4'd5, 4'd10, 4'd4, 4'd3, 4'd8};

  gf16_inv_seq #(.MUL_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .inValid(in_valid0), .inReady(in_ready0), .inData(in_data0),
    .outValid(out_valid0), .outReady(out_ready0), .outData(out_data0), .busy(busy0),
    .dbg_state(dbg0)
  );

  gf16_inv_seq #(.MUL_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .inValid(in_valid1), .inReady(in_ready1), .inData(in_data1),
    .outValid(out_valid1), .outReady(out_ready1), .outData(out_data1), .busy(busy1),
    .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic start0(input logic [3:0] a);
    in_valid0 = 1'b1;
    in_data0  = a;
    @(negedge clk);
    in_valid0 = 1'b0;
  endtask

  task automatic start1(input logic [3:0] a);
    in_valid1 = 1'b1;
    in_data1  = a;
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  // Counts cycles from the accept edge until outValid is seen, bounded.
  task automatic wait_valid0(output int cyc);
    cyc = 0;
    while (out_valid0 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_valid1(output int cyc);
    cyc = 0;
    while (out_valid1 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    int cyc;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy0); end
    checks++; if (out_data0 !== 4'd0) begin errors++; $display("FAIL rst_out_data: got %0d expected 0", out_data0); end
    checks++; if (dbg0 !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg0); end
    checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL rst_lat1: got valid=%b ready=%b expected valid=0 ready=1", out_valid1, in_ready1);
    end
    rst = 1'b0;
    @(negedge clk);
    start0(4'd7);
    @(negedge clk);
    checks++; if (dbg0 !== 3'd2) begin errors++; $display("FAIL mid_state: got %0d expected 2", dbg0); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready0); end
    checks++; if (busy0 !== 1'b0 || out_data0 !== 4'd0) begin
      errors++; $display("FAIL abort_busy_data: got busy=%b data=%0d expected busy=0 data=0", busy0, out_data0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start0(4'd2);
    wait_valid0(cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL post_rst_latency: got %0d expected 5", cyc); end
    checks++; if (out_data0 !== 4'd9) begin errors++; $display("FAIL post_rst_data: got %0d expected 9", out_data0); end
    @(negedge clk);
  endtask

  task automatic test_table;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      start0(4'(i));
      wait_valid0(cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL table_latency a=%0d: got %0d expected 5", i, cyc); end
      checks++; if (out_data0 !== INV_TAB[i]) begin
        errors++; $display("FAIL table_data a=%0d: got %0d expected %0d", i, out_data0, INV_TAB[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready0 = 1'b0;
    start0(4'd8);
    wait_valid0(cyc);
    checks++; if (out_data0 !== 4'd15) begin errors++; $display("FAIL bp_data: got %0d expected 15", out_data0); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b1 || out_data0 !== 4'd15 || in_ready0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b data=%0d ready=%b expected valid=1 data=15 ready=0",
                 k, out_valid0, out_data0, in_ready0);
      end
    end
    out_ready0 = 1'b1;
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid0, in_ready0);
    end
  endtask

  task automatic test_busy_ignore;
    int   cyc;
    logic leaked;
    in_valid0 = 1'b1;
    in_data0  = 4'd3;
    @(negedge clk);
    in_data0 = 4'd5;
    cyc      = 0;
    leaked   = 1'b0;
    while (out_valid0 !== 1'b1 && cyc < 40) begin
      if (in_ready0 !== 1'b0) leaked = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checks++; if (leaked !== 1'b0) begin errors++; $display("FAIL busy_ready_leak: got 1 expected 0"); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL busy_latency: got %0d expected 5", cyc); end
    checks++; if (out_data0 !== 4'd14) begin errors++; $display("FAIL busy_data: got %0d expected 14", out_data0); end
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL busy_done_ready: got %b expected 0", in_ready0); end
    @(negedge clk);
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL busy_idle_ready: got %b expected 1", in_ready0); end
    @(negedge clk);
    in_valid0 = 1'b0;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL busy_reaccept: got %b expected 0", in_ready0); end
    wait_valid0(cyc);
    checks++; if (out_data0 !== 4'd11) begin errors++; $display("FAIL busy_second_data: got %0d expected 11", out_data0); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    in_valid0 = 1'b1;
    in_data0  = 4'd2;
    @(negedge clk);
    in_data0 = 4'd15;
    wait_valid0(cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", cyc); end
    checks++; if (out_data0 !== 4'd9) begin errors++; $display("FAIL b2b_first_data: got %0d expected 9", out_data0); end
    @(negedge clk);
    checks++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: got ready=%b valid=%b expected ready=1 valid=0", in_ready0, out_valid0);
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b expected 0", in_ready0); end
    wait_valid0(cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 5", cyc); end
    checks++; if (out_data0 !== 4'd8) begin errors++; $display("FAIL b2b_second_data: got %0d expected 8", out_data0); end
    @(negedge clk);
  endtask

  task automatic test_latency1;
    int cyc;
    start1(4'd3);
    wait_valid1(cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL lat1_latency: got %0d expected 10", cyc); end
    checks++; if (out_data1 !== 4'd14) begin errors++; $display("FAIL lat1_data: got %0d expected 14", out_data1); end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      start1(4'(i));
      wait_valid1(cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL lat1_table_latency a=%0d: got %0d expected 10", i, cyc); end
      checks++; if (out_data1 !== INV_TAB[i]) begin
        errors++; $display("FAIL lat1_table_data a=%0d: got %0d expected %0d", i, out_data1, INV_TAB[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_table();
    test_backpressure();
    test_busy_ignore();
    test_back_to_back();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
